// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one variable-latency memory port between the instruction-fetch
// requester (read-only) and the MEM-stage data requester (read/write).
// Each access runs IDLE -> BUSY_x -> DONE_x. The stall stays asserted while
// any request is waiting. A counter limits how many data grants in a row can
// pass an instruction fetch that is waiting.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   if_req_i / if_addr_i         instruction fetch request and address
//   if_rdata_o / if_ready_o      fetched word and one-cycle completion pulse
//   dm_req_i / dm_we_i           data request, 1 = write
//   dm_addr_i / dm_wdata_i       data address and write data
//   dm_rdata_o / dm_ready_o      read data and one-cycle completion pulse
//   mem_req_o / mem_we_o         backing memory request and write strobe
//   mem_addr_o / mem_wdata_o     backing memory address and write data
//   mem_rdata_i / mem_ack_i      backing memory read data and completion
//   stall_o                      global pipeline stall
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ready_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ready_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              stall_o
);

    typedef enum logic [2:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        DONE_I,
        DONE_D
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t            state_q, state_d;
    logic [3:0]        starve_q, starve_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;

        case (state_q)
            IDLE: begin
                // Data normally wins a tie because it belongs to the older
                // instruction. Once the counter reaches the limit, the
                // waiting fetch takes the grant instead.
                if (dm_req_i && !(if_req_i && (starve_q == STARVE_LIM))) begin
                    state_d     = BUSY_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we_i;
                    mem_addr_d  = dm_addr_i;
                    mem_wdata_d = dm_wdata_i;
                    if (if_req_i) begin
                        if (starve_q != STARVE_LIM) begin
                            starve_d = starve_q + 4'd1;
                        end
                    end else begin
                        starve_d = '0;
                    end
                end else if (if_req_i) begin
                    state_d    = BUSY_I;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr_i;
                    starve_d   = '0;
                end else begin
                    starve_d = '0;
                end
            end
            BUSY_I: begin
                if (mem_ack_i) begin
                    state_d    = DONE_I;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    if_rdata_d = mem_rdata_i;
                end
            end
            BUSY_D: begin
                // A write completion must not overwrite the last read data.
                if (mem_ack_i) begin
                    state_d   = DONE_D;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (!mem_we_q) begin
                        dm_rdata_d = mem_rdata_i;
                    end
                end
            end
            DONE_I, DONE_D: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign if_ready_o  = (state_q == DONE_I);
    assign dm_ready_o  = (state_q == DONE_D);
    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

    // The stall is combinational so that it drops in a requester's own
    // ready cycle. The pipeline can then advance on that same edge.
    assign stall_o = (if_req_i & ~if_ready_o) | (dm_req_i & ~dm_ready_o);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter. A cycle-by-cycle vector table covers
// reset, a fetch, a data write, a spurious ack and a data read. Hand-written
// sequences cover grant fairness, reset during an access and back-to-back
// fetches.
module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_ready_o;
    logic        dm_req_i;
    logic        dm_we_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic [31:0] dm_rdata_o;
    logic        dm_ready_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;
    logic        stall_o;

    int nCompared = 0;
    int nMismatched = 0;

    mem_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .STARVE_MAX(4)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .if_req_i(if_req_i),
        .if_addr_i(if_addr_i),
        .if_rdata_o(if_rdata_o),
        .if_ready_o(if_ready_o),
        .dm_req_i(dm_req_i),
        .dm_we_i(dm_we_i),
        .dm_addr_i(dm_addr_i),
        .dm_wdata_i(dm_wdata_i),
        .dm_rdata_o(dm_rdata_o),
        .dm_ready_o(dm_ready_o),
        .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i),
        .mem_ack_i(mem_ack_i),
        .stall_o(stall_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        ifReq;
        logic [31:0] ifAddr;
        logic        dmReq;
        logic        dmWe;
        logic [31:0] dmAddr;
        logic [31:0] dmWdata;
        logic        memAck;
        logic [31:0] memRdata;
        logic        eMemReq;
        logic        eMemWe;
        logic [31:0] eMemAddr;
        logic [31:0] eMemWdata;
        logic        eIfReady;
        logic        eDmReady;
        logic        eStall;
        logic [31:0] eIfRdata;
        logic [31:0] eDmRdata;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(
        input logic ifReq, input logic [31:0] ifAddr,
        input logic dmReq, input logic dmWe,
        input logic [31:0] dmAddr, input logic [31:0] dmWdata,
        input logic memAck, input logic [31:0] memRdata,
        input logic eMemReq, input logic eMemWe,
        input logic [31:0] eMemAddr, input logic [31:0] eMemWdata,
        input logic eIfReady, input logic eDmReady, input logic eStall,
        input logic [31:0] eIfRdata, input logic [31:0] eDmRdata
    );
        vec_t v;
        v.ifReq = ifReq;       v.ifAddr = ifAddr;
        v.dmReq = dmReq;       v.dmWe = dmWe;
        v.dmAddr = dmAddr;     v.dmWdata = dmWdata;
        v.memAck = memAck;     v.memRdata = memRdata;
        v.eMemReq = eMemReq;   v.eMemWe = eMemWe;
        v.eMemAddr = eMemAddr; v.eMemWdata = eMemWdata;
        v.eIfReady = eIfReady; v.eDmReady = eDmReady;
        v.eStall = eStall;
        v.eIfRdata = eIfRdata; v.eDmRdata = eDmRdata;
        vecs.push_back(v);
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        if_req_i    = v.ifReq;
        if_addr_i   = v.ifAddr;
        dm_req_i    = v.dmReq;
        dm_we_i     = v.dmWe;
        dm_addr_i   = v.dmAddr;
        dm_wdata_i  = v.dmWdata;
        mem_ack_i   = v.memAck;
        mem_rdata_i = v.memRdata;
    endtask

    task automatic checkOutput(input int idx, input vec_t v);
        checkVal($sformatf("v%0d mem_req", idx), 32'(mem_req_o), 32'(v.eMemReq));
        checkVal($sformatf("v%0d mem_we", idx), 32'(mem_we_o), 32'(v.eMemWe));
        checkVal($sformatf("v%0d mem_addr", idx), mem_addr_o, v.eMemAddr);
        checkVal($sformatf("v%0d mem_wdata", idx), mem_wdata_o, v.eMemWdata);
        checkVal($sformatf("v%0d if_ready", idx), 32'(if_ready_o), 32'(v.eIfReady));
        checkVal($sformatf("v%0d dm_ready", idx), 32'(dm_ready_o), 32'(v.eDmReady));
        checkVal($sformatf("v%0d stall", idx), 32'(stall_o), 32'(v.eStall));
        checkVal($sformatf("v%0d if_rdata", idx), if_rdata_o, v.eIfRdata);
        checkVal($sformatf("v%0d dm_rdata", idx), dm_rdata_o, v.eDmRdata);
    endtask

    // One bench cycle with an instantly acknowledging memory: the ack follows
    // mem_req_o, so every access completes in the first busy cycle.
    task automatic respondCycle();
        @(negedge clk_i);
        mem_ack_i = mem_req_o;
        #1;
    endtask

    // Backstop against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        string grants;
        string expGrants;
        logic  prevReq;
        logic  seen;
        int    cyc;

        // Row layout: if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ack,
        // mem_rdata | mem_req, mem_we, mem_addr, mem_wdata, if_ready, dm_ready,
        // stall, if_rdata, dm_rdata
        // Fetch from 0x10, with the ack in the second busy cycle.
        addVec(1, 32'h10, 0, 0, 0, 0, 0, 0,                   0, 0, 32'h00, 0, 0, 0, 1, 0, 0);
        addVec(1, 32'h10, 0, 0, 0, 0, 0, 0,                   1, 0, 32'h10, 0, 0, 0, 1, 0, 0);
        addVec(1, 32'h10, 0, 0, 0, 0, 1, 32'h8C220004,        1, 0, 32'h10, 0, 0, 0, 1, 0, 0);
        addVec(1, 32'h10, 0, 0, 0, 0, 0, 0,                   0, 0, 32'h10, 0, 1, 0, 0, 32'h8C220004, 0);
        addVec(0, 0, 0, 0, 0, 0, 0, 0,                        0, 0, 32'h10, 0, 0, 0, 0, 32'h8C220004, 0);
        // Data write to 0x20; the read data bus carries junk that must not be captured.
        addVec(0, 0, 1, 1, 32'h20, 32'h12345678, 0, 0,        0, 0, 32'h10, 0, 0, 0, 1, 32'h8C220004, 0);
        addVec(0, 0, 1, 1, 32'h20, 32'h12345678, 1, 32'hDEADBEEF,
                                                              1, 1, 32'h20, 32'h12345678, 0, 0, 1, 32'h8C220004, 0);
        addVec(0, 0, 1, 1, 32'h20, 32'h12345678, 0, 0,        0, 0, 32'h20, 32'h12345678, 0, 1, 0, 32'h8C220004, 0);
        // Spurious ack in IDLE.
        addVec(0, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFF,             0, 0, 32'h20, 32'h12345678, 0, 0, 0, 32'h8C220004, 0);
        addVec(0, 0, 0, 0, 0, 0, 0, 0,                        0, 0, 32'h20, 32'h12345678, 0, 0, 0, 32'h8C220004, 0);
        // Data read from 0x24 with a one-cycle wait.
        addVec(0, 0, 1, 0, 32'h24, 32'hAAAAAAAA, 0, 0,        0, 0, 32'h20, 32'h12345678, 0, 0, 1, 32'h8C220004, 0);
        addVec(0, 0, 1, 0, 32'h24, 32'hAAAAAAAA, 0, 0,        1, 0, 32'h24, 32'hAAAAAAAA, 0, 0, 1, 32'h8C220004, 0);
        addVec(0, 0, 1, 0, 32'h24, 32'hAAAAAAAA, 1, 32'h0BADF00D,
                                                              1, 0, 32'h24, 32'hAAAAAAAA, 0, 0, 1, 32'h8C220004, 0);
        addVec(0, 0, 1, 0, 32'h24, 32'hAAAAAAAA, 0, 0,        0, 0, 32'h24, 32'hAAAAAAAA, 0, 1, 0, 32'h8C220004, 32'h0BADF00D);
        addVec(0, 0, 0, 0, 0, 0, 0, 0,                        0, 0, 32'h24, 32'hAAAAAAAA, 0, 0, 0, 32'h8C220004, 32'h0BADF00D);

        // Reset state.
        rst_i = 1'b1;
        if_req_i = 0; if_addr_i = 0; dm_req_i = 0; dm_we_i = 0;
        dm_addr_i = 0; dm_wdata_i = 0; mem_ack_i = 0; mem_rdata_i = 0;
        @(negedge clk_i);
        #1;
        checkVal("rst mem_req", 32'(mem_req_o), 0);
        checkVal("rst mem_we", 32'(mem_we_o), 0);
        checkVal("rst mem_addr", mem_addr_o, 0);
        checkVal("rst mem_wdata", mem_wdata_o, 0);
        checkVal("rst if_ready", 32'(if_ready_o), 0);
        checkVal("rst dm_ready", 32'(dm_ready_o), 0);
        checkVal("rst stall", 32'(stall_o), 0);
        checkVal("rst if_rdata", if_rdata_o, 0);
        checkVal("rst dm_rdata", dm_rdata_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk_i);
            applyStimulus(vecs[i]);
            #1;
            checkOutput(i, vecs[i]);
        end

        // Both requesters held continuously with instant acks.
        if_req_i = 1; if_addr_i = 32'h100;
        dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h200; dm_wdata_i = 0;
        mem_rdata_i = 32'h0;
        grants = "";
        expGrants = "DDDDIDDDDI";
        prevReq = 1'b0;
        for (int c = 0; c < 60 && grants.len() < 10; c++) begin
            respondCycle();
            if (mem_req_o && !prevReq) begin
                grants = {grants, (mem_addr_o == 32'h200) ? "D" : "I"};
            end
            prevReq = mem_req_o;
        end
        checkVal("grant count", 32'(grants.len()), 32'd10);
        for (int g = 0; g < 10; g++) begin
            if (g < grants.len()) begin
                checkVal($sformatf("grant %0d (0x44=D 0x49=I)", g), 32'(grants[g]), 32'(expGrants[g]));
            end
        end
        if_req_i = 0; dm_req_i = 0;
        for (int c = 0; c < 4; c++) respondCycle();
        mem_ack_i = 0;

        // Reset during a data read.
        @(negedge clk_i);
        dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h40;
        @(negedge clk_i);
        #1;
        checkVal("busy mem_req", 32'(mem_req_o), 1);
        checkVal("busy mem_addr", mem_addr_o, 32'h40);
        #1;
        rst_i = 1'b1;
        #1;
        checkVal("async rst mem_req", 32'(mem_req_o), 0);
        checkVal("async rst mem_addr", mem_addr_o, 0);
        checkVal("async rst dm_rdata", dm_rdata_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        dm_req_i = 0;
        seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            mem_ack_i = 1'b1;
            #1;
            if (dm_ready_o) seen = 1'b1;
        end
        mem_ack_i = 0;
        checkVal("no ready after rst", 32'(seen), 0);

        // Fresh data read after reset.
        @(negedge clk_i);
        dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h44;
        mem_rdata_i = 32'h55AA55AA;
        #1;
        cyc = 0;
        while (!dm_ready_o && cyc < 10) begin
            respondCycle();
            cyc++;
        end
        checkVal("fresh read ready", 32'(dm_ready_o), 1);
        checkVal("fresh read latency", cyc, 2);
        checkVal("fresh read rdata", dm_rdata_o, 32'h55AA55AA);
        dm_req_i = 0;
        mem_ack_i = 0;

        // Back-to-back fetches with the address changing in the DONE cycle.
        @(negedge clk_i);
        if_req_i = 1; if_addr_i = 32'h0;
        mem_rdata_i = 32'h11111111;
        #1;
        cyc = 0;
        while (!if_ready_o && cyc < 10) begin
            respondCycle();
            cyc++;
        end
        checkVal("fetch1 ready", 32'(if_ready_o), 1);
        checkVal("fetch1 rdata", if_rdata_o, 32'h11111111);
        if_addr_i = 32'h4;
        mem_rdata_i = 32'h22222222;
        respondCycle();
        checkVal("fetch gap mem_req", 32'(mem_req_o), 0);
        respondCycle();
        checkVal("fetch2 mem_req", 32'(mem_req_o), 1);
        checkVal("fetch2 mem_addr", mem_addr_o, 32'h4);
        cyc = 0;
        while (!if_ready_o && cyc < 10) begin
            respondCycle();
            cyc++;
        end
        checkVal("fetch2 ready", 32'(if_ready_o), 1);
        checkVal("fetch2 rdata", if_rdata_o, 32'h22222222);
        if_req_i = 0;
        mem_ack_i = 0;
        @(negedge clk_i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
